// File: rtl/pov_pkg.sv
// Shared types and default parameters for the POV display rotation-sensor front end.
package pov_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        ARMED      = 2'd1,
        RUN        = 2'd2,
        STALL      = 2'd3
    } sensor_state_t;

    localparam int unsigned SENSOR_DEBOUNCE_DEF = 16;
    localparam int unsigned SENSOR_CNT_W_DEF    = 32;
    localparam int unsigned SENSOR_TIMEOUT_DEF  = 50_000_000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debounce counter for the raw hall-sensor pin.
// rise_c flags the cycle whose clock edge will take clean from 0 to 1.
module sensor_debounce
    import pov_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise_c
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync_q,  sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            clean_q, clean_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            db_cnt_q <= '0;
            clean_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            clean_q  <= clean_d;
        end
    end

    // clean only follows sync_q after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        sync1_d  = raw;
        sync_d   = sync1_q;
        db_cnt_d = db_cnt_q;
        clean_d  = clean_q;
        if (sync_q == clean_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            clean_d  = sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign clean  = clean_q;
    assign rise_c = clean_d & ~clean_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Rotation-sensor conditioner: debounced level, revolution pulse, period and stall flag.
// Define SENSOR_PERIOD_AVG_EN to report the mean of the last two measurements.
module sensor_conditioner
    import pov_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SENSOR_DEBOUNCE_DEF,
    parameter int unsigned CNT_W           = SENSOR_CNT_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = SENSOR_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_raw,
    output logic             sensor_clean,
    output logic             rev_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic rise_c;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_raw),
        .clean (sensor_clean),
        .rise_c(rise_c)
    );

    sensor_state_t    state_q, state_d;
    logic             rev_pulse_q, rev_pulse_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             stalled_q, stalled_d;
    logic [CNT_W-1:0] meas_c;
    logic             timeout_c;
`ifdef SENSOR_PERIOD_AVG_EN
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W:0]   avg_sum_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= WAIT_FIRST;
            rev_pulse_q    <= 1'b0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
`ifdef SENSOR_PERIOD_AVG_EN
            prev_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rev_pulse_q    <= rev_pulse_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
`ifdef SENSOR_PERIOD_AVG_EN
            prev_q         <= prev_d;
`endif
        end
    end

    // per_cnt saturates at PER_MAX, so meas_c never exceeds TIMEOUT_CYCLES
    always_comb begin
        rev_pulse_d = rise_c;
        meas_c      = per_cnt_q + CNT_W'(1);
        timeout_c   = (per_cnt_q == PER_MAX);
        if (rev_pulse_q) begin
            per_cnt_d = '0;
        end else if (timeout_c) begin
            per_cnt_d = per_cnt_q;
        end else begin
            per_cnt_d = meas_c;
        end
    end

`ifdef SENSOR_PERIOD_AVG_EN
    assign avg_sum_c = {1'b0, meas_c} + {1'b0, prev_q};
`endif

    // Revolution FSM; a pulse coinciding with timeout takes priority over the stall
    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;
`ifdef SENSOR_PERIOD_AVG_EN
        prev_d         = prev_q;
`endif
        case (state_q)
            WAIT_FIRST: begin
                if (rev_pulse_q) begin
                    state_d = ARMED;
`ifdef SENSOR_PERIOD_AVG_EN
                    prev_d  = '0;
`endif
                end
            end
            ARMED: begin
                if (rev_pulse_q) begin
                    state_d        = RUN;
`ifdef SENSOR_PERIOD_AVG_EN
                    prev_d         = meas_c;
`else
                    period_d       = meas_c;
                    period_valid_d = 1'b1;
`endif
                end else if (timeout_c) begin
                    state_d        = STALL;
                    stalled_d      = 1'b1;
                    period_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (rev_pulse_q) begin
`ifdef SENSOR_PERIOD_AVG_EN
                    period_d       = avg_sum_c[CNT_W:1];
                    prev_d         = meas_c;
                    period_valid_d = 1'b1;
`else
                    period_d       = meas_c;
`endif
                end else if (timeout_c) begin
                    state_d        = STALL;
                    stalled_d      = 1'b1;
                    period_valid_d = 1'b0;
                end
            end
            STALL: begin
                if (rev_pulse_q) begin
                    state_d   = ARMED;
                    stalled_d = 1'b0;
`ifdef SENSOR_PERIOD_AVG_EN
                    prev_d    = '0;
`endif
                end
            end
            default: begin
                state_d = WAIT_FIRST;
            end
        endcase
    end

    assign rev_pulse    = rev_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (DEBOUNCE 16, TIMEOUT 5000); expectations
// follow SENSOR_PERIOD_AVG_EN when that macro is defined for the build.
module tb_sensor_conditioner;
    import pov_pkg::*;

    localparam int unsigned DEB   = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned TMO   = 5000;
`ifdef SENSOR_PERIOD_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    // Expected periods at the labelled points of the sequence
    localparam longint EXP_A = AVG ? 0 : 1000;
    localparam longint EXP_C = AVG ? 1100 : 1200;
    localparam longint EXP_D = AVG ? EXP_C : 1000;
    localparam longint EXP_E = AVG ? 3000 : 5000;
    localparam longint EXP_F = AVG ? 3000 : 1001;

    logic          clk;
    logic          reset;
    logic          sensor_raw;
    logic          sensor_clean;
    logic          rev_pulse;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          stalled;

    int n_checks;
    int n_fail;
    int since;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_raw  (sensor_raw),
        .sensor_clean(sensor_clean),
        .rev_pulse   (rev_pulse),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        since += n;
    endtask

    // Next raw rise lands exactly gap cycles after the previous one
    task automatic next_rise(input int gap);
        tick(gap / 2 - since);
        sensor_raw = 1'b0;
        tick(gap - since);
        sensor_raw = 1'b1;
        since = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_clean"}, 64'(sensor_clean), 64'd0);
        chk({tag, "_pulse"}, 64'(rev_pulse), 64'd0);
        chk({tag, "_period"}, 64'(period), 64'd0);
        chk({tag, "_valid"}, 64'(period_valid), 64'd0);
        chk({tag, "_stalled"}, 64'(stalled), 64'd0);
        chk({tag, "_state"}, 64'(dut.state_q), 64'(WAIT_FIRST));
    endtask

    initial begin
        logic seen;
        n_checks   = 0;
        n_fail     = 0;
        since      = 0;
        reset      = 1'b1;
        sensor_raw = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(5);
        check_idle("reset");

        // 10-cycle glitch must not get through
        sensor_raw = 1'b1;
        tick(10);
        sensor_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            seen = seen | sensor_clean | rev_pulse;
        end
        chk("glitch_rejected", 64'(seen), 64'd0);

        // Stable rise: clean exactly 18 edges later, single pulse
        sensor_raw = 1'b1;
        since = 0;
        tick(17);
        chk("rise1_clean_early", 64'(sensor_clean), 64'd0);
        tick(1);
        chk("rise1_clean", 64'(sensor_clean), 64'd1);
        chk("rise1_pulse", 64'(rev_pulse), 64'd1);
        tick(1);
        chk("rise1_pulse_width", 64'(rev_pulse), 64'd0);
        chk("rise1_valid", 64'(period_valid), 64'd0);
        chk("rise1_state", 64'(dut.state_q), 64'(ARMED));

        // Second edge 1000 cycles later
        next_rise(1000);
        tick(18);
        chk("rise2_pulse", 64'(rev_pulse), 64'd1);
        chk("rise2_valid_early", 64'(period_valid), 64'd0);
        tick(1);
        chk("rise2_period", 64'(period), 64'(EXP_A));
        chk("rise2_valid", 64'(period_valid), 64'(!AVG));

        next_rise(1000);
        tick(19);
        chk("rise3_period", 64'(period), 64'd1000);
        chk("rise3_valid", 64'(period_valid), 64'd1);

        next_rise(1200);
        tick(18);
        chk("rise4_period_held", 64'(period), 64'd1000);
        tick(1);
        chk("rise4_period", 64'(period), 64'(EXP_C));

        // Stop toggling: stall once per_cnt saturates
        tick(5018 - since);
        chk("stall_early", 64'(stalled), 64'd0);
        chk("stall_early_valid", 64'(period_valid), 64'd1);
        tick(1);
        chk("stall_flag", 64'(stalled), 64'd1);
        chk("stall_valid", 64'(period_valid), 64'd0);
        chk("stall_period_held", 64'(period), 64'(EXP_C));
        chk("stall_state", 64'(dut.state_q), 64'(STALL));

        // Restart; the falling edge must not pulse
        sensor_raw = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            seen = seen | rev_pulse;
        end
        chk("fall_no_pulse", 64'(seen), 64'd0);
        sensor_raw = 1'b1;
        since = 0;
        tick(18);
        chk("restart_pulse", 64'(rev_pulse), 64'd1);
        tick(1);
        chk("restart_stalled", 64'(stalled), 64'd0);
        chk("restart_valid", 64'(period_valid), 64'd0);
        chk("restart_state", 64'(dut.state_q), 64'(ARMED));

        next_rise(1000);
        tick(19);
        chk("restart2_period", 64'(period), 64'(EXP_D));
        chk("restart2_valid", 64'(period_valid), 64'(!AVG));
        chk("restart2_state", 64'(dut.state_q), 64'(RUN));

        // Pulse arrives in the same cycle as the timeout
        next_rise(int'(TMO));
        tick(18);
        chk("race_pulse", 64'(rev_pulse), 64'd1);
        chk("race_stalled_pre", 64'(stalled), 64'd0);
        tick(1);
        chk("race_period", 64'(period), 64'(EXP_E));
        chk("race_valid", 64'(period_valid), 64'd1);
        chk("race_stalled", 64'(stalled), 64'd0);
        tick(50);
        chk("race_stalled_late", 64'(stalled), 64'd0);
        chk("race_state", 64'(dut.state_q), 64'(RUN));

        next_rise(1001);
        tick(19);
        chk("odd_period", 64'(period), 64'(EXP_F));

        // Asynchronous reset in the middle of a revolution
        tick(200);
        #2;
        reset      = 1'b1;
        sensor_raw = 1'b0;
        #1;
        check_idle("midreset");
        tick(5);
        reset = 1'b0;
        tick(40);
        check_idle("idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front end for the rotation sensor of the POV display. Sits directly upstream of the display top and drives its sensor input.
- Synchronises the raw hall-sensor pin, debounces it, and emits a single-cycle revolution pulse on each debounced rising edge.
- Measures the revolution period in clk cycles and flags a stalled wheel, so downstream pixel timing gets a clean edge and a trustworthy period.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronised samples that must disagree with sensor_clean before it toggles; legal range is 2 or more.
- CNT_W, 32: width of the period counter and of the period output.
- TIMEOUT_CYCLES, 50_000_000: cycles without a revolution pulse before the stall flag is raised; must be no greater than 2^CNT_W-1.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-high reset.
- sensor_raw  in  1  raw, asynchronous sensor pin.
- sensor_clean  out  1  synchronised, debounced sensor level.
- rev_pulse  out  1  one-cycle pulse on each rising edge of sensor_clean.
- period  out  CNT_W  clk cycles between the last two rev_pulses.
- period_valid  out  1  high when period holds a real measurement.
- stalled  out  1  high when no rev_pulse has arrived for TIMEOUT_CYCLES.

Behaviour:
- Reset (async, active-high): all outputs are 0, the sync flops are 0, the counters are 0, and the FSM is in WAIT_FIRST.
- Sync: two flops give sync_q; sensor_raw is never used except through them.
- Debounce:
  - db_cnt is cleared whenever sync_q == sensor_clean.
  - Otherwise db_cnt increments.
  - When db_cnt == DEBOUNCE_CYCLES-1 and sync_q != sensor_clean: sensor_clean <= sync_q and db_cnt <= 0.
  - Latency from a stable raw change to sensor_clean is DEBOUNCE_CYCLES+2 clk edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected.
- rev_pulse:
  - Registered; high for exactly one cycle, on the same edge where sensor_clean goes 0->1.
  - A falling edge produces no pulse.
- per_cnt:
  - Cleared to 0 in the cycle after any rev_pulse.
  - Otherwise increments, and stops at TIMEOUT_CYCLES-1 (never wraps).
- FSM states: WAIT_FIRST, ARMED, RUN, STALL.
  - WAIT_FIRST: on rev_pulse go to ARMED and restart per_cnt. Nothing is latched.
  - ARMED: on rev_pulse latch period <= per_cnt+1, set period_valid = 1, go to RUN.
  - RUN: on every rev_pulse latch period <= per_cnt+1.
  - ARMED or RUN, per_cnt == TIMEOUT_CYCLES-1 with no rev_pulse: go to STALL. stalled <= 1, period_valid <= 0, and period holds its last value.
  - STALL: on rev_pulse clear stalled, restart per_cnt, go to ARMED. The first period after a stall is discarded.
- Simultaneous rev_pulse and timeout in the same cycle: the pulse wins and no stall is raised.
- Width: period is CNT_W bits. per_cnt+1 cannot overflow because per_cnt saturates below TIMEOUT_CYCLES.
- Reset asserted mid-revolution: everything returns to reset values immediately, with no partial period output.

Optional Feature:
- Macro SENSOR_PERIOD_AVG_EN.
- Defined:
  - period is the mean of the new and previous raw measurements, computed as (new+prev)>>1 in a CNT_W+1-bit intermediate and truncated to CNT_W.
  - prev is updated on every latch and cleared on entry to ARMED.
  - period_valid rises only after the second measurement in RUN, which is the third rev_pulse after WAIT_FIRST or STALL.
- Undefined: period is the raw latest measurement, exactly as above.

Decomposition:
- Package pov_pkg holds:
  - typedef enum logic [1:0] sensor_state_t with WAIT_FIRST, ARMED, RUN, STALL;
  - default constants SENSOR_DEBOUNCE_DEF, SENSOR_CNT_W_DEF, SENSOR_TIMEOUT_DEF.
- One sub-module, sensor_debounce, contains the 2-flop sync and the debounce counter.
  - Ports: clk, reset, raw in, clean out.
  - Parameter: DEBOUNCE_CYCLES.
- The top contains the edge detect, per_cnt and the FSM.

Test Plan:
- Reset and idle: assert reset mid-run, then hold sensor_raw = 0 -> all outputs are 0 and the state is WAIT_FIRST.
- Debounce (DEBOUNCE_CYCLES=16): a 10-cycle high glitch on sensor_raw -> sensor_clean and rev_pulse stay 0. A stable high -> sensor_clean rises exactly 18 edges later, with a single 1-cycle rev_pulse.
- Period: rising edges 1000 cycles apart -> no period_valid after the 1st edge. After the 2nd edge period = 1000 and period_valid = 1. Changing to 1200-cycle spacing -> period = 1200 after the next edge.
- Stall (TIMEOUT_CYCLES=5000): stop toggling after RUN -> stalled = 1 and period_valid = 0 exactly 5000 cycles after the last rev_pulse, with period held. Restart -> stalled clears on the first pulse; period_valid returns on the second.
- Race: place a rev_pulse in the same cycle per_cnt hits TIMEOUT_CYCLES-1 -> no stall, and period = TIMEOUT_CYCLES.
- With SENSOR_PERIOD_AVG_EN: spacings 1000 then 1001 -> period = 1000 (truncated), period_valid from the third pulse.
